sr_mc_control: RTL and testbench
================================

# sr_mc_control

Multi-cycle sequencer for the schoolRISCV datapath. It drives one instruction through FETCH, DECODE, EXEC and WB states over a single shared ALU, register file and instruction-memory port. It replaces the single-cycle combinational control when the core runs against a memory with variable response latency. It also traps on unsupported encodings and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  instruction fetch request to memory.
- `imem_ack`  in  1  fetch data valid. Only meaningful while `imem_req`=1.
- `cmdOp`  in  7  opcode field from the instruction register.
- `cmdF3`  in  3  funct3 field from the instruction register.
- `cmdF7`  in  7  funct7 field from the instruction register.
- `aluZero`  in  1  ALU result-equals-zero flag.
- `irWrite`  out  1  load the instruction register from memory data.
- `pcWrite`  out  1  update the PC.
- `pcSrc`  out  1  PC source select: 0 = PC+4, 1 = branch target.
- `regWrite`  out  1  register-file write enable.
- `aluSrc`  out  1  ALU operand B select: 0 = rs2, 1 = immediate.
- `wdSrc`  out  1  writeback data select: 0 = ALU result, 1 = U-immediate.
- `aluControl`  out  4  ALU operation, encoded with the `ALU_*` codes.
- `halted`  out  1  core is stopped in TRAP.
- `instr_count`  out  CNT_W  number of retired instructions.

## Operation
- States:
  - FETCH:
    - `imem_req` = 1.
    - On `imem_ack`=1: `irWrite`=1 for that cycle, then go to DECODE.
    - On `imem_ack`=0: stay in FETCH.
  - DECODE: classify the instruction register and latch `cls` and `aluControl` into registers.
    - Invalid encoding: go to TRAP.
    - Any valid encoding: go to EXEC.
  - EXEC: `aluControl` is driven from the register; `aluSrc` = 1 for ADDI.
    - BRANCH class:
      - Take the branch if (BEQ and `aluZero`) or (BNE and !`aluZero`).
      - Assert `pcWrite`=1, with `pcSrc` = taken.
      - Retire the instruction, then go to FETCH.
    - All other classes: go to WB.
  - WB:
    - Drive `regWrite`=1 and `pcWrite`=1 with `pcSrc`=0.
    - Keep `aluControl`, `aluSrc` and `wdSrc` held at their EXEC values.
    - Retire the instruction, then go to FETCH.
  - TRAP: `halted`=1, all enables 0, no exit except `rst`.
- Classes `cls`: ALU_R, ALU_I, LUI, BRANCH, INVALID.
- ALU_R: opcode 0110011.
  - funct7 = 0000000 with funct3 000/001/010/011/100/101/110/111 → ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 = 0100000 with funct3 000 → SUB; with funct3 101 → SRA.
  - Any other funct7/funct3 pair is INVALID.
- ALU_I: ADDI only, opcode 0010011 with funct3 000; uses `ALU_ADD`.
- LUI: opcode 0110111; `wdSrc`=1 in EXEC and WB.
- BRANCH: opcode 1100011.
  - funct3 000 → BEQ, funct3 001 → BNE, both using `ALU_SUB`.
  - Any other funct3 is INVALID.
- Everything not listed above is INVALID.
- Default outputs in every state: all enables 0, `aluControl` = `ALU_ADD`.
- `instr_count` increments by 1 on each retire and wraps modulo 2^CNT_W.

## Timing
- Reset:
  - State goes to FETCH and `instr_count` to 0.
  - `cls` and held `aluControl` reset to INVALID and `ALU_ADD`.
  - All outputs are 0, including `imem_req`, because it is gated by !`rst`.
  - Reset in any state, TRAP included, aborts the instruction. No `regWrite` or `pcWrite` is issued in the reset cycle.
- Latency with `imem_ack` returned in the first FETCH cycle:
  - ALU_R, ALU_I, LUI: 4 cycles per instruction.
  - BRANCH: 3 cycles per instruction.
  - Each cycle of `imem_ack` delay adds one cycle.
- `imem_req` stays high continuously until the ack. `imem_ack` outside FETCH is ignored.
- `aluZero` is sampled only in EXEC.
- `cmdOp`, `cmdF3` and `cmdF7` are sampled only in DECODE. They may change after DECODE without effect.
- `halted` asserts the cycle after DECODE of an invalid instruction. `instr_count` does not increment for that instruction.
- Count wrap: all-ones plus a retire gives 0 in the next cycle.

## Structure
- The state enum typedef (FETCH, DECODE, EXEC, WB, TRAP) and the class enum typedef go in the shared `sr_cpu.svh`, next to the existing `RVOP_*`, `RVF3_*`, `RVF7_*` and `ALU_*` constants.
- Sub-module `sr_mc_decode` is purely combinational: fields in → class, `aluControl` and branch-sense bit out.
- `sr_mc_control` holds the state register, the latched decode result and the counter.

## Test plan
- **ADD, zero-wait memory.** Reset, then ADD (0000000/000/0110011) with ack in the first FETCH cycle.
  - Expected: `irWrite`@1, `aluControl`=`ALU_ADD`@3, `regWrite`=`pcWrite`=1@4, `instr_count`=1 after cycle 4.
- **BEQ both ways.**
  - `aluZero`=1 → `pcWrite`=1 and `pcSrc`=1 in EXEC.
  - `aluZero`=0 → `pcWrite`=1 and `pcSrc`=0.
  - Expected: no WB cycle in either case; 3 cycles per instruction.
- **Delayed ack.** Ack delayed 5 cycles.
  - Expected: `imem_req` high for 6 cycles; `irWrite` pulses exactly once; LUI completes in 9 cycles with `wdSrc`=1 in EXEC and WB.
- **Invalid encodings.** SUB with funct7 = 0000001, and branch funct3 = 100.
  - Expected: TRAP; `halted`=1; `instr_count` unchanged; `imem_req` stays 0 afterwards until `rst`.
- **Reset mid-WB, and counter wrap.**
  - Assert `rst` in WB → no `regWrite` that cycle; FETCH with `imem_req`=1 one cycle after `rst` falls.
  - With CNT_W=4, run 16 retires → `instr_count` returns to 0.

Source files
------------

// File: rtl/sr_mc_control_pkg.sv
// Shared definitions for the multi-cycle schoolRISCV control path.
// Holds the RISC-V field encodings the decoder recognises, the 4-bit ALU
// operation codes driven on aluControl, and the sequencer state and
// instruction-class enums used by sr_mc_decode and sr_mc_control.
package sr_mc_control_pkg;

    // Opcodes
    localparam logic [6:0] RVOP_ALU_R  = 7'b0110011;
    localparam logic [6:0] RVOP_ADDI   = 7'b0010011;
    localparam logic [6:0] RVOP_LUI    = 7'b0110111;
    localparam logic [6:0] RVOP_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] RVF3_ADD  = 3'b000;
    localparam logic [2:0] RVF3_SLL  = 3'b001;
    localparam logic [2:0] RVF3_SLT  = 3'b010;
    localparam logic [2:0] RVF3_SLTU = 3'b011;
    localparam logic [2:0] RVF3_XOR  = 3'b100;
    localparam logic [2:0] RVF3_SRL  = 3'b101;
    localparam logic [2:0] RVF3_OR   = 3'b110;
    localparam logic [2:0] RVF3_AND  = 3'b111;
    localparam logic [2:0] RVF3_ADDI = 3'b000;
    localparam logic [2:0] RVF3_BEQ  = 3'b000;
    localparam logic [2:0] RVF3_BNE  = 3'b001;

    // funct7 values
    localparam logic [6:0] RVF7_BASE = 7'b0000000;
    localparam logic [6:0] RVF7_ALT  = 7'b0100000;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_TRAP   = 3'd4
    } mc_state_e;

    typedef enum logic [2:0] {
        CLS_ALU_R   = 3'd0,
        CLS_ALU_I   = 3'd1,
        CLS_LUI     = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_INVALID = 3'd4
    } mc_cls_e;

endpackage

// File: rtl/sr_mc_decode.sv
// Combinational instruction classifier.
// Ports:
//   cmd_op_i / cmd_f3_i / cmd_f7_i : opcode, funct3, funct7 fields
//   cls_o                          : instruction class (mc_cls_e encoding)
//   alu_ctrl_o                     : ALU operation for EXEC/WB
//   br_ne_o                        : 1 for BNE (branch on non-zero), 0 otherwise
// Anything not explicitly recognised is reported as CLS_INVALID with ALU_ADD.
module sr_mc_decode
    import sr_mc_control_pkg::*;
(
    input  logic [6:0] cmd_op_i,
    input  logic [2:0] cmd_f3_i,
    input  logic [6:0] cmd_f7_i,
    output logic [2:0] cls_o,
    output logic [3:0] alu_ctrl_o,
    output logic       br_ne_o
);

    mc_cls_e    cls;
    logic [3:0] alu_ctrl;
    logic       br_ne;

    always_comb begin
        cls      = CLS_INVALID;
        alu_ctrl = ALU_ADD;
        br_ne    = 1'b0;
        case (cmd_op_i)
            RVOP_ALU_R: begin
                if (cmd_f7_i == RVF7_BASE) begin
                    cls = CLS_ALU_R;
                    case (cmd_f3_i)
                        RVF3_ADD:  alu_ctrl = ALU_ADD;
                        RVF3_SLL:  alu_ctrl = ALU_SLL;
                        RVF3_SLT:  alu_ctrl = ALU_SLT;
                        RVF3_SLTU: alu_ctrl = ALU_SLTU;
                        RVF3_XOR:  alu_ctrl = ALU_XOR;
                        RVF3_SRL:  alu_ctrl = ALU_SRL;
                        RVF3_OR:   alu_ctrl = ALU_OR;
                        default:   alu_ctrl = ALU_AND;
                    endcase
                end else if (cmd_f7_i == RVF7_ALT && cmd_f3_i == RVF3_ADD) begin
                    cls      = CLS_ALU_R;
                    alu_ctrl = ALU_SUB;
                end else if (cmd_f7_i == RVF7_ALT && cmd_f3_i == RVF3_SRL) begin
                    cls      = CLS_ALU_R;
                    alu_ctrl = ALU_SRA;
                end
            end
            RVOP_ADDI: begin
                // funct7 carries immediate bits here and is deliberately ignored
                if (cmd_f3_i == RVF3_ADDI) begin
                    cls = CLS_ALU_I;
                end
            end
            RVOP_LUI: begin
                cls = CLS_LUI;
            end
            RVOP_BRANCH: begin
                // Both branches compare by subtraction and test aluZero
                if (cmd_f3_i == RVF3_BEQ) begin
                    cls      = CLS_BRANCH;
                    alu_ctrl = ALU_SUB;
                end else if (cmd_f3_i == RVF3_BNE) begin
                    cls      = CLS_BRANCH;
                    alu_ctrl = ALU_SUB;
                    br_ne    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cls_o      = cls;
    assign alu_ctrl_o = alu_ctrl;
    assign br_ne_o    = br_ne;

endmodule

// File: rtl/sr_mc_control.sv
// Multi-cycle sequencer for the schoolRISCV datapath.
// Steps each instruction through FETCH -> DECODE -> EXEC (-> WB), traps on
// unsupported encodings and counts retired instructions.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   imem_req / imem_ack       : instruction fetch handshake
//   cmdOp, cmdF3, cmdF7       : instruction register fields (sampled in DECODE)
//   aluZero                   : ALU zero flag (sampled in EXEC)
//   irWrite, pcWrite, pcSrc   : IR load, PC update and PC source select
//   regWrite, aluSrc, wdSrc   : register write, ALU operand B and WB data select
//   aluControl                : ALU operation
//   halted                    : core stopped in TRAP
//   instr_count               : retired-instruction counter, wraps
module sr_mc_control
    import sr_mc_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [6:0]       cmdOp,
    input  logic [2:0]       cmdF3,
    input  logic [6:0]       cmdF7,
    input  logic             aluZero,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             pcSrc,
    output logic             regWrite,
    output logic             aluSrc,
    output logic             wdSrc,
    output logic [3:0]       aluControl,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    mc_state_e        state_q, state_d;
    mc_cls_e          cls_q, cls_d;
    logic [3:0]       alu_q, alu_d;
    logic             bne_q, bne_d;
    logic [CNT_W-1:0] cnt_q;

    logic [2:0] dec_cls;
    logic [3:0] dec_alu;
    logic       dec_bne;

    logic       retire;
    logic       br_taken;
    logic       imem_req_c, ir_write_c, pc_write_c, pc_src_c;
    logic       reg_write_c, alu_src_c, wd_src_c, halted_c;
    logic [3:0] alu_ctrl_c;

    sr_mc_decode u_decode (
        .cmd_op_i   (cmdOp),
        .cmd_f3_i   (cmdF3),
        .cmd_f7_i   (cmdF7),
        .cls_o      (dec_cls),
        .alu_ctrl_o (dec_alu),
        .br_ne_o    (dec_bne)
    );

    // BEQ takes on zero, BNE on non-zero
    assign br_taken = aluZero ^ bne_q;

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        alu_d       = alu_q;
        bne_d       = bne_q;
        retire      = 1'b0;
        imem_req_c  = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 1'b0;
        reg_write_c = 1'b0;
        alu_src_c   = 1'b0;
        wd_src_c    = 1'b0;
        halted_c    = 1'b0;
        alu_ctrl_c  = ALU_ADD;
        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_write_c = 1'b1;
                    state_d    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d   = mc_cls_e'(dec_cls);
                alu_d   = dec_alu;
                bne_d   = dec_bne;
                state_d = (mc_cls_e'(dec_cls) == CLS_INVALID) ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                alu_ctrl_c = alu_q;
                alu_src_c  = (cls_q == CLS_ALU_I);
                wd_src_c   = (cls_q == CLS_LUI);
                if (cls_q == CLS_BRANCH) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = br_taken;
                    retire     = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                // Datapath selects stay at their EXEC values while writing back
                alu_ctrl_c  = alu_q;
                alu_src_c   = (cls_q == CLS_ALU_I);
                wd_src_c    = (cls_q == CLS_LUI);
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                retire      = 1'b1;
                state_d     = ST_FETCH;
            end
            ST_TRAP: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_INVALID;
            alu_q   <= ALU_ADD;
            bne_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            alu_q   <= alu_d;
            bne_q   <= bne_d;
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Reset masks every control output so an aborted instruction cannot
    // write the register file or PC in the reset cycle.
    assign imem_req    = imem_req_c  & ~rst;
    assign irWrite     = ir_write_c  & ~rst;
    assign pcWrite     = pc_write_c  & ~rst;
    assign pcSrc       = pc_src_c    & ~rst;
    assign regWrite    = reg_write_c & ~rst;
    assign aluSrc      = alu_src_c   & ~rst;
    assign wdSrc       = wd_src_c    & ~rst;
    assign halted      = halted_c    & ~rst;
    assign aluControl  = rst ? ALU_ADD : alu_ctrl_c;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_sr_mc_control.sv
module tb_sr_mc_control;
    import sr_mc_control_pkg::*;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 16;

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LUI = 2;
    localparam int K_BR  = 3;
    localparam int K_INV = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             imem_req;
    logic             imem_ack = 1'b0;
    logic [6:0]       cmdOp = '0;
    logic [2:0]       cmdF3 = '0;
    logic [6:0]       cmdF7 = '0;
    logic             aluZero = 1'b0;
    logic             irWrite, pcWrite, pcSrc, regWrite, aluSrc, wdSrc, halted;
    logic [3:0]       aluControl;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;
    int cnt_model = 0;
    int txn = 0;

    sr_mc_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .cmdOp       (cmdOp),
        .cmdF3       (cmdF3),
        .cmdF7       (cmdF7),
        .aluZero     (aluZero),
        .irWrite     (irWrite),
        .pcWrite     (pcWrite),
        .pcSrc       (pcSrc),
        .regWrite    (regWrite),
        .aluSrc      (aluSrc),
        .wdSrc       (wdSrc),
        .aluControl  (aluControl),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_junk();
        cmdOp    = 7'($urandom);
        cmdF3    = 3'($urandom);
        cmdF7    = 7'($urandom);
        aluZero  = 1'($urandom);
        imem_ack = 1'($urandom);
    endtask

    // Reference classification straight from the instruction set table.
    function automatic void classify(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7, output int kind,
                                     output logic [3:0] alu, output logic bne);
        logic [3:0] base_tab [8];
        base_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        kind = K_INV;
        alu  = ALU_ADD;
        bne  = 1'b0;
        if (op == 7'b0110011 && f7 == 7'b0000000) begin
            kind = K_R;
            alu  = base_tab[f3];
        end else if (op == 7'b0110011 && f7 == 7'b0100000 && f3 == 3'd0) begin
            kind = K_R;
            alu  = ALU_SUB;
        end else if (op == 7'b0110011 && f7 == 7'b0100000 && f3 == 3'd5) begin
            kind = K_R;
            alu  = ALU_SRA;
        end else if (op == 7'b0010011 && f3 == 3'd0) begin
            kind = K_I;
        end else if (op == 7'b0110111) begin
            kind = K_LUI;
        end else if (op == 7'b1100011 && f3 <= 3'd1) begin
            kind = K_BR;
            alu  = ALU_SUB;
            bne  = f3[0];
        end
    endfunction

    // Entry and exit: 1 time unit after a rising edge with the DUT in FETCH.
    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_junk();
            #3;
            check("rst_req",   imem_req, 0);
            check("rst_irw",   irWrite,  0);
            check("rst_regw",  regWrite, 0);
            check("rst_pcw",   pcWrite,  0);
            check("rst_halt",  halted,   0);
            next_cycle();
        end
        rst = 1'b0;
        cnt_model = 0;
        check("rst_count", instr_count, 0);
        $display("txn %0d reset count=%0d", txn, instr_count);
        txn++;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input int delay, input logic zero, input bit wb_rst,
                             output bit trapped);
        int         kind;
        logic [3:0] alu;
        logic       bne;
        int         cycles;
        classify(op, f3, f7, kind, alu, bne);
        trapped = 1'b0;
        cycles  = 0;
        for (int c = 0; c <= delay; c++) begin
            drive_junk();
            imem_ack = (c == delay);
            #3;
            check("fetch_req",  imem_req, 1);
            check("fetch_irw",  irWrite,  32'(c == delay));
            check("fetch_regw", regWrite, 0);
            next_cycle();
            cycles++;
        end
        // DECODE: the only cycle in which the fields must be valid
        drive_junk();
        cmdOp = op;
        cmdF3 = f3;
        cmdF7 = f7;
        #3;
        check("dec_req", imem_req,   0);
        check("dec_irw", irWrite,    0);
        check("dec_pcw", pcWrite,    0);
        check("dec_alu", aluControl, 32'(ALU_ADD));
        next_cycle();
        cycles++;
        if (kind == K_INV) begin
            for (int i = 0; i < 3; i++) begin
                drive_junk();
                #3;
                check("trap_halt",  halted,      1);
                check("trap_req",   imem_req,    0);
                check("trap_pcw",   pcWrite,     0);
                check("trap_regw",  regWrite,    0);
                check("trap_count", instr_count, 32'(cnt_model));
                next_cycle();
            end
            trapped = 1'b1;
            $display("txn %0d op=%b f3=%b f7=%b delay=%0d -> trap count=%0d",
                     txn, op, f3, f7, delay, instr_count);
            txn++;
            return;
        end
        // EXEC
        drive_junk();
        aluZero = zero;
        #3;
        check("exec_alu",    aluControl, 32'(alu));
        check("exec_alusrc", aluSrc,     32'(kind == K_I));
        check("exec_wdsrc",  wdSrc,      32'(kind == K_LUI));
        check("exec_regw",   regWrite,   0);
        check("exec_halt",   halted,     0);
        check("exec_count",  instr_count, 32'(cnt_model));
        if (kind == K_BR) begin
            check("exec_pcw",   pcWrite, 1);
            check("exec_pcsrc", pcSrc,   32'(bne ? !zero : zero));
            next_cycle();
            cycles++;
            cnt_model = (cnt_model + 1) % CNT_MOD;
        end else begin
            check("exec_pcw", pcWrite, 0);
            next_cycle();
            cycles++;
            // WB
            drive_junk();
            if (wb_rst) rst = 1'b1;
            #3;
            if (wb_rst) begin
                check("wbrst_regw", regWrite, 0);
                check("wbrst_pcw",  pcWrite,  0);
                check("wbrst_req",  imem_req, 0);
                next_cycle();
                rst = 1'b0;
                cnt_model = 0;
            end else begin
                check("wb_regw",   regWrite,   1);
                check("wb_pcw",    pcWrite,    1);
                check("wb_pcsrc",  pcSrc,      0);
                check("wb_alu",    aluControl, 32'(alu));
                check("wb_alusrc", aluSrc,     32'(kind == K_I));
                check("wb_wdsrc",  wdSrc,      32'(kind == K_LUI));
                next_cycle();
                cnt_model = (cnt_model + 1) % CNT_MOD;
            end
            cycles++;
        end
        check("next_count", instr_count, 32'(cnt_model));
        $display("txn %0d op=%b f3=%b f7=%b delay=%0d zero=%0d cycles=%0d count=%0d",
                 txn, op, f3, f7, delay, zero, cycles, instr_count);
        txn++;
    endtask

    initial begin
        bit         tr;
        int         sel;
        logic [6:0] op, f7;
        logic [2:0] f3;

        next_cycle();
        do_reset();

        // ADD, zero-wait
        run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 1'b0, 1'b0, tr);
        // BEQ / BNE both ways
        run_instr(7'b1100011, 3'b000, 7'h55, 0, 1'b1, 1'b0, tr);
        run_instr(7'b1100011, 3'b000, 7'h2a, 0, 1'b0, 1'b0, tr);
        run_instr(7'b1100011, 3'b001, 7'h00, 0, 1'b0, 1'b0, tr);
        run_instr(7'b1100011, 3'b001, 7'h7f, 0, 1'b1, 1'b0, tr);
        // LUI with a 5-cycle ack delay
        run_instr(7'b0110111, 3'b011, 7'h13, 5, 1'b0, 1'b0, tr);
        // ADDI
        run_instr(7'b0010011, 3'b000, 7'h41, 1, 1'b1, 1'b0, tr);
        // Invalid: SUB with bad funct7, branch funct3 100
        run_instr(7'b0110011, 3'b000, 7'b0000001, 0, 1'b0, 1'b0, tr);
        do_reset();
        run_instr(7'b1100011, 3'b100, 7'b0000000, 2, 1'b0, 1'b0, tr);
        do_reset();
        // Reset during WB
        run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 1'b0, 1'b0, tr);
        run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 1'b0, 1'b1, tr);
        drive_junk();
        #3;
        check("post_rst_req",   imem_req,    1);
        check("post_rst_count", instr_count, 0);
        next_cycle();
        // The bench is now one cycle into FETCH; realign with a fresh reset
        do_reset();

        // Counter wrap: 16 retires bring a 4-bit count back to 0
        for (int i = 0; i < 16; i++) begin
            run_instr(7'b0010011, 3'b000, 7'($urandom), 0, 1'b0, 1'b0, tr);
        end
        check("wrap_zero", instr_count, 0);

        // Randomised mix
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            op  = 7'($urandom);
            f3  = 3'($urandom);
            f7  = 7'($urandom);
            case (sel)
                0, 1, 2: begin op = 7'b0110011; f7 = 7'b0000000; end
                3:       begin op = 7'b0110011; f7 = 7'b0100000; f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5; end
                4:       begin op = 7'b0010011; f3 = 3'd0; end
                5:       op = 7'b0110111;
                6, 7:    begin op = 7'b1100011; f3 = 3'($urandom_range(0, 1)); end
                8:       op = 7'b0110011;
                default: ;
            endcase
            run_instr(op, f3, f7, $urandom_range(0, 3), 1'($urandom), 1'b0, tr);
            if (tr) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
